// File: rtl/gcd_binary_engine.sv
// Binary (Stein) GCD engine with valid/ready handshakes on both sides and a tag carried with each result.
// Optional build macro GCD_CYCLE_COUNT_EN adds the out_cycles port (cycles spent in STRIP/REDUCE).
module gcd_binary_engine #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int CNT_W = $clog2(2*WIDTH+4),
    localparam int K_W   = $clog2(WIDTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [TAG_W-1:0] out_tag
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_cycles
`endif
);

    // state  | meaning
    // IDLE   | waiting for an operand pair
    // STRIP  | removing common factors of two into k
    // REDUCE | Stein reduction until a==b
    // DONE   | result held until the sink takes it
    typedef enum logic [1:0] {IDLE, STRIP, REDUCE, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt, gcd_q, gcd_nxt;
    logic [K_W-1:0]   k_q, k_nxt;
    logic [TAG_W-1:0] tag_q, tag_nxt;
    logic             accept, zero_op;

    assign in_ready  = (state == IDLE) && !sys_rst;
    assign accept    = in_valid && in_ready;
    assign zero_op   = (in_a == '0) || (in_b == '0);
    assign out_valid = (state == DONE);
    assign out_gcd   = gcd_q;
    assign out_tag   = tag_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            k_q   <= '0;
            tag_q <= '0;
            gcd_q <= '0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            k_q   <= k_nxt;
            tag_q <= tag_nxt;
            gcd_q <= gcd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        k_nxt     = k_q;
        tag_nxt   = tag_q;
        gcd_nxt   = gcd_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    a_nxt   = in_a;
                    b_nxt   = in_b;
                    tag_nxt = in_tag;
                    k_nxt   = '0;
                    if (zero_op) begin
                        gcd_nxt   = in_a | in_b;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = STRIP;
                    end
                end
            end
            STRIP: begin
                if (!a_q[0] && !b_q[0]) begin
                    a_nxt = a_q >> 1;
                    b_nxt = b_q >> 1;
                    k_nxt = k_q + 1'b1;
                end else begin
                    state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                // the compare guarantees the subtractions never underflow
                if (a_q == b_q) begin
                    gcd_nxt   = a_q << k_q;
                    state_nxt = DONE;
                end else if (!a_q[0]) begin
                    a_nxt = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_nxt = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_nxt = (a_q - b_q) >> 1;
                end else begin
                    b_nxt = (b_q - a_q) >> 1;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cyc_q;

    assign out_cycles = cyc_q;

    // zero-operand results report a single cycle; the counter saturates rather than wraps
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cyc_q <= '0;
        end else if (accept) begin
            cyc_q <= zero_op ? CNT_W'(1) : '0;
        end else if ((state == STRIP || state == REDUCE) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_binary_engine.sv
// Directed self-checking bench for gcd_binary_engine; checks out_cycles too when GCD_CYCLE_COUNT_EN is defined.
module tb_gcd_binary_engine;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(2*WIDTH+4);
    localparam int MAX_LAT = 2*WIDTH+2;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_gcd;
    logic [TAG_W-1:0] out_tag;
`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] out_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    gcd_binary_engine #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gcd   (out_gcd),
        .out_tag   (out_tag)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .out_cycles(out_cycles)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one pair, wait for the result, check it; consume it only if out_ready is high.
    task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] tg, input logic [WIDTH-1:0] exp_g, input int exp_lat);
        int guard;
        int lat;
        guard    = 0;
        in_a     = a;
        in_b     = b;
        in_tag   = tg;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge sys_clk); #1;
            guard++;
        end
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_gcd"}, 32'(out_gcd), 32'(exp_g));
        chk({name, "_tag"}, 32'(out_tag), 32'(tg));
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_lat_bound"}, 32'(lat <= MAX_LAT), 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
        if (a == '0 || b == '0)
            chk({name, "_cycles"}, 32'(out_cycles), 32'd1);
        else
            chk({name, "_cycles"}, 32'(out_cycles), 32'(lat - 1));
`endif
        if (out_ready) begin
            @(posedge sys_clk); #1;
            chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
            chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int seen_valid;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_gcd", 32'(out_gcd), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        #20;
        sys_rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        @(posedge sys_clk); #1;

        do_op("t24_18", 16'd24, 16'd18, 4'd3, 16'd6, 7);
        do_op("t0_66", 16'd0, 16'd66, 4'd1, 16'd66, 1);
        do_op("t0_0", 16'd0, 16'd0, 4'd2, 16'd0, 1);
        do_op("t66_0", 16'd66, 16'd0, 4'd4, 16'd66, 1);
        do_op("tffff", 16'hFFFF, 16'hFFFF, 4'd5, 16'hFFFF, 3);
        do_op("tpow2", 16'd32768, 16'd16384, 4'd6, 16'd16384, 18);
        do_op("t894_18", 16'd894, 16'd18, 4'd8, 16'd6, 12);
        do_op("t105_99", 16'd105, 16'd99, 4'd9, 16'd3, 9);

        // back-pressure: hold the result while a new pair is offered
        out_ready = 1'b0;
        do_op("thold", 16'd48, 16'd36, 4'd5, 16'd12, 8);
        in_a     = 16'd9;
        in_b     = 16'd3;
        in_tag   = 4'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_gcd", 32'(out_gcd), 32'd12);
            chk("hold_tag", 32'(out_tag), 32'd5);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_gcd", 32'(out_gcd), 32'd12);

        // reset mid-REDUCE of (105,99)
        in_a     = 16'd105;
        in_b     = 16'd99;
        in_tag   = 4'd2;
        in_valid = 1'b1;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("mid_busy", 32'(in_ready), 32'd0);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_gcd", 32'(out_gcd), 32'd0);
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk); #1;
            if (out_valid) seen_valid++;
        end
        chk("mid_no_result", 32'(seen_valid), 32'd0);
        do_op("t894_18_post", 16'd894, 16'd18, 4'd7, 16'd6, 12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
